// File: rtl/rsa_multi_wrapper_if.sv
// Arm<->FPGA command/data bus for the multi-channel RSA wrapper.
// Handshakes: command is a one-cycle cmd_valid strobe sampled only in IDLE; an inbound
// beat transfers on the edge where arm_to_fpga_data_valid is high while the wrapper
// sits in LOAD (arm_to_fpga_data_ready marks LOAD, one cycle late); an outbound beat is
// presented as fpga_to_arm_data_valid with data, and the host must hold
// fpga_to_arm_data_ready high to let it go; fpga_to_arm_done is held until done_read.
interface rsa_multi_wrapper_if #(
  parameter int TX_SIZE = 1024
);
  logic [31:0]        arm_to_fpga_cmd;
  logic               arm_to_fpga_cmd_valid;
  logic               fpga_to_arm_done;
  logic               fpga_to_arm_done_read;
  logic               arm_to_fpga_data_valid;
  logic               arm_to_fpga_data_ready;
  logic [TX_SIZE-1:0] arm_to_fpga_data;
  logic               fpga_to_arm_data_valid;
  logic               fpga_to_arm_data_ready;
  logic [TX_SIZE-1:0] fpga_to_arm_data;

  modport master (
    output arm_to_fpga_cmd, arm_to_fpga_cmd_valid, fpga_to_arm_done_read,
    output arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
    input  fpga_to_arm_done, arm_to_fpga_data_ready,
    input  fpga_to_arm_data_valid, fpga_to_arm_data
  );

  modport slave (
    input  arm_to_fpga_cmd, arm_to_fpga_cmd_valid, fpga_to_arm_done_read,
    input  arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
    output fpga_to_arm_done, arm_to_fpga_data_ready,
    output fpga_to_arm_data_valid, fpga_to_arm_data
  );
endinterface

// File: rtl/rsa_multi_wrapper.sv
// Command front-end for NUM_CH independent modular-exponentiation cores: loads operands,
// launches channels non-blocking, captures results and answers result/status reads.
module rsa_multi_wrapper #(
  parameter int TX_SIZE = 1024,
  parameter int OP_W    = 512,
  parameter int NUM_CH  = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  rsa_multi_wrapper_if.slave       bus,
  output logic [NUM_CH-1:0]        core_resetn,
  output logic [NUM_CH-1:0]        core_start,
  output logic [NUM_CH-1:0]        core_mul_en,
  output logic [NUM_CH*OP_W-1:0]   core_modulus,
  output logic [NUM_CH*OP_W-1:0]   core_rmodm,
  output logic [NUM_CH*OP_W-1:0]   core_rsqmodm,
  output logic [NUM_CH*OP_W-1:0]   core_exponent,
  output logic [NUM_CH*OP_W-1:0]   core_x,
  input  logic [NUM_CH-1:0]        core_done,
  input  logic [NUM_CH*OP_W-1:0]   core_result,
  output logic                     err,
  output logic [3:0]               leds
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] OP_ILLEGAL       = 3'd0;
  localparam logic [2:0] OP_MONT          = 3'd1;
  localparam logic [2:0] OP_LOAD_MOD      = 3'd2;
  localparam logic [2:0] OP_LOAD_RSQ_X    = 3'd3;
  localparam logic [2:0] OP_LOAD_EXP_RMOD = 3'd4;
  localparam logic [2:0] OP_READ          = 3'd5;
  localparam logic [2:0] OP_EXP           = 3'd6;
  localparam logic [2:0] OP_STATUS        = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_LOAD        = 4'd1,
    S_LAUNCH_INIT = 4'd2,
    S_LAUNCH_GO   = 4'd3,
    S_WAIT_RES    = 4'd4,
    S_WRITE       = 4'd5,
    S_DONE        = 4'd6
  } state_t;

  state_t              state, state_d;
  logic [2:0]          cur_op;
  logic [CH_W-1:0]     cur_ch;
  logic [NUM_CH-1:0]   running, res_valid, fall_pend;
  logic [OP_W-1:0]     result_reg [NUM_CH];
  logic                data_ready_q, out_valid_q, done_q;
  logic [TX_SIZE-1:0]  out_data_q;

  logic [2:0]          cmd_op;
  logic [1:0]          cmd_ch;
  logic [CH_W-1:0]     cmd_ch_idx;
  logic                cmd_bad, cmd_launch, cmd_load, cmd_busy;
  logic                wait_hit;
  int                  ch_base;
  logic [TX_SIZE-1:0]  status_word;

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{bus.arm_to_fpga_cmd[31:6], bus.arm_to_fpga_cmd[3]};

  if (TX_SIZE > 2*OP_W) begin : g_unused_data
    logic unused_data_bits;
    assign unused_data_bits = ^bus.arm_to_fpga_data[TX_SIZE-1:2*OP_W];
  end

  always_comb begin
    cmd_op     = bus.arm_to_fpga_cmd[2:0];
    cmd_ch     = bus.arm_to_fpga_cmd[5:4];
    cmd_ch_idx = cmd_ch[CH_W-1:0];
    cmd_bad    = (cmd_op == OP_ILLEGAL) || (32'(cmd_ch) >= NUM_CH);
    cmd_launch = (cmd_op == OP_MONT) || (cmd_op == OP_EXP);
    cmd_load   = (cmd_op == OP_LOAD_MOD) || (cmd_op == OP_LOAD_RSQ_X) ||
                 (cmd_op == OP_LOAD_EXP_RMOD);
    cmd_busy   = cmd_launch && running[cmd_ch_idx];
    // A result arriving while we wait is taken on its capture edge.
    wait_hit   = res_valid[cur_ch] || (running[cur_ch] && core_done[cur_ch]);
    ch_base    = int'(cur_ch) * OP_W;
    status_word             = '0;
    status_word[NUM_CH-1:0] = running;
    status_word[4 +: NUM_CH] = res_valid;
    status_word[8]          = err;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (bus.arm_to_fpga_cmd_valid) begin
          if (cmd_bad || cmd_busy)       state_d = S_DONE;
          else if (cmd_load)             state_d = S_LOAD;
          else if (cmd_launch)           state_d = S_LAUNCH_INIT;
          else if (cmd_op == OP_READ)    state_d = S_WAIT_RES;
          else                           state_d = S_WRITE;
        end
      end
      S_LOAD:        if (bus.arm_to_fpga_data_valid) state_d = S_DONE;
      S_LAUNCH_INIT: state_d = S_LAUNCH_GO;
      S_LAUNCH_GO:   state_d = S_DONE;
      S_WAIT_RES:    if (wait_hit) state_d = S_WRITE;
      S_WRITE:       if (bus.fpga_to_arm_data_ready) state_d = S_DONE;
      S_DONE:        if (bus.fpga_to_arm_done_read) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_op        <= OP_ILLEGAL;
      cur_ch        <= '0;
      running       <= '0;
      res_valid     <= '0;
      fall_pend     <= '0;
      err           <= 1'b0;
      core_resetn   <= '0;
      core_start    <= '0;
      core_mul_en   <= '0;
      core_modulus  <= '0;
      core_rmodm    <= '0;
      core_rsqmodm  <= '0;
      core_exponent <= '0;
      core_x        <= '0;
      data_ready_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      out_data_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) result_reg[c] <= '0;
    end else begin
      data_ready_q <= (state == S_LOAD);
      out_valid_q  <= (state == S_WRITE);
      done_q       <= (state == S_DONE);

      // Per-channel completion runs regardless of the command FSM; a launch below wins.
      for (int c = 0; c < NUM_CH; c++) begin
        if (fall_pend[c]) begin
          core_start[c]  <= 1'b0;
          core_resetn[c] <= 1'b0;
          fall_pend[c]   <= 1'b0;
        end
        if (running[c] && core_done[c]) begin
          result_reg[c] <= core_result[c*OP_W +: OP_W];
          res_valid[c]  <= 1'b1;
          running[c]    <= 1'b0;
          fall_pend[c]  <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (bus.arm_to_fpga_cmd_valid) begin
            cur_op <= cmd_op;
            cur_ch <= cmd_ch_idx;
            if (cmd_bad || cmd_busy) err <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.arm_to_fpga_data_valid) begin
            case (cur_op)
              OP_LOAD_MOD: core_modulus[ch_base +: OP_W] <= bus.arm_to_fpga_data[OP_W-1:0];
              OP_LOAD_RSQ_X: begin
                core_rsqmodm[ch_base +: OP_W] <= bus.arm_to_fpga_data[OP_W-1:0];
                core_x[ch_base +: OP_W]       <= bus.arm_to_fpga_data[2*OP_W-1:OP_W];
              end
              OP_LOAD_EXP_RMOD: begin
                core_exponent[ch_base +: OP_W] <= bus.arm_to_fpga_data[OP_W-1:0];
                core_rmodm[ch_base +: OP_W]    <= bus.arm_to_fpga_data[2*OP_W-1:OP_W];
              end
              default: ;
            endcase
          end
        end
        S_LAUNCH_INIT: begin
          core_resetn[cur_ch] <= 1'b1;
          core_mul_en[cur_ch] <= (cur_op == OP_MONT);
          running[cur_ch]     <= 1'b1;
          res_valid[cur_ch]   <= 1'b0;
          fall_pend[cur_ch]   <= 1'b0;
        end
        S_LAUNCH_GO: core_start[cur_ch] <= 1'b1;
        S_WRITE: begin
          out_data_q <= (cur_op == OP_READ) ?
                        {{(TX_SIZE-OP_W){1'b0}}, result_reg[cur_ch]} : status_word;
          if (bus.fpga_to_arm_data_ready) begin
            if (cur_op == OP_STATUS) err <= 1'b0;
            else                     res_valid[cur_ch] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.arm_to_fpga_data_ready = data_ready_q;
  assign bus.fpga_to_arm_data_valid = out_valid_q;
  assign bus.fpga_to_arm_data       = out_data_q;
  assign bus.fpga_to_arm_done       = done_q;
  assign leds                       = state;
endmodule

// File: tb/tb_rsa_multi_wrapper.sv
// Bench for rsa_multi_wrapper: behavioural cores with programmable latency and an
// operation-level model of channel/operand/error state, driven with random operands.
module tb_rsa_multi_wrapper;
  localparam int TX_SIZE = 1024;
  localparam int OP_W    = 512;
  localparam int NUM_CH  = 2;

  localparam logic [2:0] OP_MONT = 3'd1, OP_LOAD_MOD = 3'd2, OP_LOAD_RSQ_X = 3'd3;
  localparam logic [2:0] OP_LOAD_EXP_RMOD = 3'd4, OP_READ = 3'd5, OP_EXP = 3'd6;
  localparam logic [2:0] OP_STATUS = 3'd7;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rsa_multi_wrapper_if #(.TX_SIZE(TX_SIZE)) bus ();

  logic [NUM_CH-1:0]      core_resetn, core_start, core_mul_en;
  logic [NUM_CH*OP_W-1:0] core_modulus, core_rmodm, core_rsqmodm, core_exponent, core_x;
  logic [NUM_CH-1:0]      core_done = '0;
  logic [NUM_CH*OP_W-1:0] core_result = '0;
  logic                   err;
  logic [3:0]             leds;

  rsa_multi_wrapper #(.TX_SIZE(TX_SIZE), .OP_W(OP_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .core_resetn(core_resetn), .core_start(core_start), .core_mul_en(core_mul_en),
    .core_modulus(core_modulus), .core_rmodm(core_rmodm), .core_rsqmodm(core_rsqmodm),
    .core_exponent(core_exponent), .core_x(core_x),
    .core_done(core_done), .core_result(core_result),
    .err(err), .leds(leds)
  );

  // behavioural cores: done pulses lat[c] started cycles after start, once per run
  int               lat [NUM_CH];
  logic [OP_W-1:0]  rv [NUM_CH];
  int               cnt [NUM_CH];
  bit               fired [NUM_CH];
  int               done_count [NUM_CH];

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      core_done[c] = 1'b0;
      if (core_resetn[c] !== 1'b1) begin
        cnt[c] = 0;
        fired[c] = 1'b0;
      end else if (core_start[c] === 1'b1 && !fired[c]) begin
        cnt[c]++;
        if (cnt[c] >= lat[c]) begin
          core_done[c] = 1'b1;
          core_result[c*OP_W +: OP_W] = rv[c];
          fired[c] = 1'b1;
          done_count[c]++;
        end
      end
    end
  end

  // reference model
  logic [OP_W-1:0]   m_mod [NUM_CH], m_rsq [NUM_CH], m_x [NUM_CH];
  logic [OP_W-1:0]   m_exp [NUM_CH], m_rmod [NUM_CH], m_result [NUM_CH];
  logic [NUM_CH-1:0] m_running, m_res_valid, m_mul_en;
  logic              m_err;
  int                seen [NUM_CH];

  // scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [OP_W-1:0] got, input logic [OP_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OP_W-1:0] rand_op();
    logic [OP_W-1:0] v;
    for (int i = 0; i < OP_W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_mod[c] = '0; m_rsq[c] = '0; m_x[c] = '0;
      m_exp[c] = '0; m_rmod[c] = '0; m_result[c] = '0;
      seen[c] = done_count[c];
    end
    m_running = '0; m_res_valid = '0; m_mul_en = '0; m_err = 1'b0;
  endtask

  // a core that has answered since we last looked has completed its run
  task automatic model_sync();
    for (int c = 0; c < NUM_CH; c++) begin
      if (done_count[c] != seen[c]) begin
        seen[c] = done_count[c];
        if (m_running[c]) begin
          m_running[c] = 1'b0;
          m_res_valid[c] = 1'b1;
          m_result[c] = rv[c];
        end
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input int ch);
    bus.arm_to_fpga_cmd = {26'd0, 2'(ch), 1'b0, op};
    bus.arm_to_fpga_cmd_valid = 1'b1;
    tick();
    bus.arm_to_fpga_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    while (!bus.fpga_to_arm_done && i < 2000) begin tick(); i++; end
    check({tag, " done"}, bus.fpga_to_arm_done, 1'b1);
    bus.fpga_to_arm_done_read = 1'b1;
    tick();
    bus.fpga_to_arm_done_read = 1'b0;
    tick();
  endtask

  task automatic do_load(input logic [2:0] op, input int ch, input logic [TX_SIZE-1:0] d);
    int waited = 0;
    send_cmd(op, ch);
    while (!bus.arm_to_fpga_data_ready && waited < 20) begin tick(); waited++; end
    check("load ready latency", waited, 1);
    bus.arm_to_fpga_data = d;
    bus.arm_to_fpga_data_valid = 1'b1;
    tick();
    bus.arm_to_fpga_data_valid = 1'b0;
    case (op)
      OP_LOAD_MOD:   m_mod[ch] = d[OP_W-1:0];
      OP_LOAD_RSQ_X: begin m_rsq[ch] = d[OP_W-1:0]; m_x[ch] = d[2*OP_W-1:OP_W]; end
      default:       begin m_exp[ch] = d[OP_W-1:0]; m_rmod[ch] = d[2*OP_W-1:OP_W]; end
    endcase
    wait_done("load");
  endtask

  task automatic read_out(input logic [2:0] op, input int ch, output logic [TX_SIZE-1:0] d);
    int i = 0;
    send_cmd(op, ch);
    while (!bus.fpga_to_arm_data_valid && i < 2000) begin tick(); i++; end
    check("out valid seen", bus.fpga_to_arm_data_valid, 1'b1);
    d = bus.fpga_to_arm_data;
    wait_done("read");
  endtask

  task automatic check_status(input string tag);
    logic [TX_SIZE-1:0] d;
    logic [OP_W-1:0] e;
    model_sync();
    e = '0;
    e[NUM_CH-1:0] = m_running;
    e[4 +: NUM_CH] = m_res_valid;
    e[8] = m_err;
    read_out(OP_STATUS, 0, d);
    check(tag, d[OP_W-1:0], e);
    check({tag, " upper"}, d[TX_SIZE-1:OP_W], '0);
    m_err = 1'b0;
    check({tag, " err after"}, err, m_err);
  endtask

  task automatic check_operands(input string tag);
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("%s mod ch%0d", tag, c), core_modulus[c*OP_W +: OP_W], m_mod[c]);
      check($sformatf("%s rsq ch%0d", tag, c), core_rsqmodm[c*OP_W +: OP_W], m_rsq[c]);
      check($sformatf("%s x ch%0d", tag, c), core_x[c*OP_W +: OP_W], m_x[c]);
      check($sformatf("%s exp ch%0d", tag, c), core_exponent[c*OP_W +: OP_W], m_exp[c]);
      check($sformatf("%s rmod ch%0d", tag, c), core_rmodm[c*OP_W +: OP_W], m_rmod[c]);
    end
  endtask

  task automatic check_core_ctl(input string tag);
    model_sync();
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("%s start ch%0d", tag, c), core_start[c], m_running[c]);
      check($sformatf("%s resetn ch%0d", tag, c), core_resetn[c], m_running[c]);
      check($sformatf("%s mul_en ch%0d", tag, c), core_mul_en[c], m_mul_en[c]);
    end
  endtask

  task automatic launch(input logic [2:0] op, input int ch, input int latency,
                        input logic [OP_W-1:0] result);
    model_sync();
    if (m_running[ch]) m_err = 1'b1;
    else begin
      lat[ch] = latency;
      rv[ch] = result;
      m_running[ch] = 1'b1;
      m_res_valid[ch] = 1'b0;
      m_mul_en[ch] = (op == OP_MONT);
    end
    send_cmd(op, ch);
    wait_done("launch");
    check($sformatf("launch mul_en ch%0d", ch), core_mul_en[ch], m_mul_en[ch]);
    check("launch err", err, m_err);
  endtask

  task automatic read_result(input int ch);
    logic [TX_SIZE-1:0] d;
    read_out(OP_READ, ch, d);
    model_sync();
    check($sformatf("result ch%0d", ch), d[OP_W-1:0], m_result[ch]);
    check($sformatf("result upper ch%0d", ch), d[TX_SIZE-1:OP_W], '0);
    m_res_valid[ch] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [TX_SIZE-1:0] d;
    logic [OP_W-1:0] a5;
    int ch;
    logic [2:0] bad_op [4];
    int bad_ch [4];

    bus.arm_to_fpga_cmd = '0;
    bus.arm_to_fpga_cmd_valid = 1'b0;
    bus.fpga_to_arm_done_read = 1'b0;
    bus.arm_to_fpga_data_valid = 1'b0;
    bus.arm_to_fpga_data = '0;
    bus.fpga_to_arm_data_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin lat[c] = 10; rv[c] = '0; end
    model_clear();

    // reset state
    repeat (3) tick();
    check("rst leds", leds, 4'd0);
    check("rst done", bus.fpga_to_arm_done, 1'b0);
    check("rst in ready", bus.arm_to_fpga_data_ready, 1'b0);
    check("rst out valid", bus.fpga_to_arm_data_valid, 1'b0);
    check("rst out data", bus.fpga_to_arm_data[OP_W-1:0], '0);
    check("rst err", err, 1'b0);
    check("rst core_resetn", core_resetn, '0);
    check("rst core_start", core_start, '0);
    check("rst core_mul_en", core_mul_en, '0);
    resetn = 1'b1;
    tick();

    // LOAD_MOD ch1 with the A5 pattern, then random loads on every channel/op
    a5 = {64{8'hA5}};
    do_load(OP_LOAD_MOD, 1, {{(TX_SIZE-OP_W){1'b0}}, a5});
    check_operands("a5 load");
    for (int c = 0; c < NUM_CH; c++) begin
      do_load(OP_LOAD_RSQ_X, c, {rand_op(), rand_op()});
      do_load(OP_LOAD_EXP_RMOD, c, {rand_op(), rand_op()});
    end
    check_operands("rand load");

    // two overlapping channels with very different latencies
    launch(OP_EXP, 0, 300, rand_op());
    launch(OP_MONT, 1, 50, rand_op());
    check_status("status both running");
    repeat (350) tick();
    check_status("status both done");
    read_result(1);
    read_result(0);
    check_status("status after reads");

    // read issued before the core answers parks in WAIT_RES
    launch(OP_EXP, 0, 40, 512'h1234);
    send_cmd(OP_READ, 0);
    check("wait_res entered", leds, 4'd4);
    repeat (5) tick();
    check("wait_res held", leds, 4'd4);
    check("wait_res no valid", bus.fpga_to_arm_data_valid, 1'b0);
    begin
      int i = 0;
      while (!bus.fpga_to_arm_data_valid && i < 2000) begin tick(); i++; end
    end
    check("fwd valid", bus.fpga_to_arm_data_valid, 1'b1);
    check("fwd result", bus.fpga_to_arm_data[OP_W-1:0], 512'h1234);
    check("fwd upper", bus.fpga_to_arm_data[TX_SIZE-1:OP_W], '0);
    wait_done("fwd read");
    model_sync();
    m_res_valid[0] = 1'b0;

    // randomized load / launch / read rounds
    for (int r = 0; r < 6; r++) begin
      ch = $urandom_range(0, NUM_CH-1);
      do_load(OP_LOAD_MOD, ch, {rand_op(), rand_op()});
      do_load(OP_LOAD_RSQ_X, ch, {rand_op(), rand_op()});
      do_load(OP_LOAD_EXP_RMOD, ch, {rand_op(), rand_op()});
      check_operands($sformatf("round%0d", r));
      launch(($urandom_range(0, 1) != 0) ? OP_MONT : OP_EXP, ch, $urandom_range(5, 80), rand_op());
      if ($urandom_range(0, 1) != 0) repeat (100) tick();
      read_result(ch);
    end
    repeat (5) tick();

    // illegal opcodes and out-of-range channels: error only, no core activity
    bad_op[0] = 3'd0;        bad_ch[0] = 0;
    bad_op[1] = OP_LOAD_MOD; bad_ch[1] = 3;
    bad_op[2] = OP_MONT;     bad_ch[2] = 2;
    bad_op[3] = OP_READ;     bad_ch[3] = 3;
    for (int k = 0; k < 4; k++) begin
      send_cmd(bad_op[k], bad_ch[k]);
      m_err = 1'b1;
      wait_done($sformatf("bad cmd %0d", k));
      check($sformatf("bad cmd %0d err", k), err, m_err);
      check_core_ctl($sformatf("bad cmd %0d", k));
      check_status($sformatf("bad cmd %0d status", k));
    end
    check_operands("after bad cmds");

    // relaunch on a busy channel is refused
    launch(OP_EXP, 0, 200, rand_op());
    launch(OP_EXP, 0, 5, rand_op());
    check("busy err", err, 1'b1);
    check_core_ctl("busy");
    check_status("busy status");
    check_status("busy status cleared");

    // reset while both channels compute
    launch(OP_MONT, 1, 500, rand_op());
    resetn = 1'b0;
    tick();
    check("abort core_resetn", core_resetn, '0);
    check("abort core_start", core_start, '0);
    check("abort leds", leds, 4'd0);
    check("abort done", bus.fpga_to_arm_done, 1'b0);
    resetn = 1'b1;
    model_clear();
    tick();
    check_status("status after abort");
    check_operands("operands after abort");
    check_core_ctl("ctl after abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rsa_multi_wrapper.md
RSA_MULTI_WRAPPER -- requirements
Module: rsa_multi_wrapper

Parameters
REQ-001 TX_SIZE, 1024, width of the Arm<->FPGA data bus.
REQ-002 OP_W, 512, operand width; SHALL satisfy 2*OP_W <= TX_SIZE.
REQ-003 NUM_CH, 2, number of independent exponentiation channels; legal values 1..4.

Interface
REQ-004 clk  in  1  clock; all logic is rising-edge.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 arm_to_fpga_cmd  in  32  command word: [2:0] opcode, [5:4] channel index.
REQ-007 arm_to_fpga_cmd_valid  in  1  command strobe.
REQ-008 fpga_to_arm_done / fpga_to_arm_done_read  out/in  1/1  completion flag / acknowledge.
REQ-009 arm_to_fpga_data_valid, arm_to_fpga_data_ready, arm_to_fpga_data  in/out/in  1/1/TX_SIZE  inbound data handshake.
REQ-010 fpga_to_arm_data_valid, fpga_to_arm_data_ready, fpga_to_arm_data  out/in/out  1/1/TX_SIZE  outbound data handshake.
REQ-011 core_resetn, core_start, core_mul_en  out  NUM_CH each  per-channel core controls.
REQ-012 core_modulus, core_rmodm, core_rsqmodm, core_exponent, core_x  out  NUM_CH*OP_W each  per-channel operands; channel c occupies bits [c*OP_W +: OP_W].
REQ-013 core_done  in  NUM_CH  per-channel done; core_result  in  NUM_CH*OP_W  per-channel results.
REQ-014 err  out  1  sticky error flag.
REQ-015 leds  out  4  current FSM state encoding.

Function
REQ-016 Opcodes: 1=MONT, 2=LOAD_MOD, 3=LOAD_RSQ_X, 4=LOAD_EXP_RMOD, 5=READ_RESULT, 6=EXP, 7=STATUS, 0=illegal.
REQ-017 Data mapping on load beats:
- LOAD_MOD: modulus <= data[OP_W-1:0].
- LOAD_RSQ_X: rsqmodm <= data[OP_W-1:0]; x <= data[2*OP_W-1:OP_W].
- LOAD_EXP_RMOD: exponent <= data[OP_W-1:0]; rmodm <= data[2*OP_W-1:OP_W].
- All loads write only the addressed channel.
REQ-018 FSM states: IDLE, LOAD, LAUNCH_INIT, LAUNCH_GO, WAIT_RES, WRITE, DONE.
REQ-019 IDLE SHALL transition on cmd_valid as follows:
- Loads -> LOAD.
- MONT/EXP on an idle channel -> LAUNCH_INIT.
- READ_RESULT -> WAIT_RES.
- STATUS -> WRITE.
- Illegal opcode or channel >= NUM_CH -> DONE, with err set.
REQ-020 LOAD -> DONE on the cycle arm_to_fpga_data_valid is high; operand captured on that edge.
REQ-021 LAUNCH_INIT (1 cycle):
- Raises core_resetn[c].
- Sets core_mul_en[c] = 1 for MONT, 0 for EXP.
- Sets running[c] and clears res_valid[c].
- -> LAUNCH_GO.
REQ-022 LAUNCH_GO (1 cycle): raises core_start[c]; -> DONE. Launch is non-blocking: the channel computes while the FSM accepts further commands.
REQ-023 Per channel, while running[c]:
- core_start[c] is held high until core_done[c].
- On the core_done[c] edge, result_reg[c] <= core_result[c], res_valid[c] <= 1 and running[c] <= 0.
- core_start[c] and core_resetn[c] fall on the following cycle.
REQ-024 Channels SHALL complete independently; simultaneous core_done on several channels SHALL all be captured in the same cycle.
REQ-025 MONT/EXP on a running channel SHALL set err, leave the channel untouched, and go to DONE.
REQ-026 Loads to a running channel SHALL be accepted; they take effect on the next launch only if the core samples operands at start (core contract); the wrapper does not block them.
REQ-027 WAIT_RES SHALL stay until res_valid[c]; if core_done[c] arrives in WAIT_RES, the result is forwarded on the capture cycle; -> WRITE.
REQ-028 WRITE output data:
- After WAIT_RES: fpga_to_arm_data = {zeros, result_reg[c]}.
- After STATUS: bits [NUM_CH-1:0] = running, bits [NUM_CH+3:4] = res_valid, bit 8 = err, rest zero.
REQ-029 WRITE -> DONE when fpga_to_arm_data_ready = 1; res_valid[c] is cleared on READ_RESULT completion.
REQ-030 DONE -> IDLE on fpga_to_arm_done_read.
REQ-031 Handshake outputs are registered, one cycle behind the state:
- arm_to_fpga_data_ready = (state was LOAD).
- fpga_to_arm_data_valid = (state was WRITE).
- fpga_to_arm_done = (state was DONE).
REQ-032 err is cleared only by a STATUS read or by reset.
REQ-033 cmd_valid outside IDLE SHALL be ignored.

Reset
REQ-034 On resetn = 0 at a clock edge:
- State -> IDLE.
- All operand and result registers, running, res_valid and err clear to 0.
- core_resetn, core_start, core_mul_en, done, both valid/ready outputs and fpga_to_arm_data go to 0.
REQ-035 Reset mid-computation SHALL abort all channels (core_resetn low on the next edge); a core_done arriving during reset is discarded.

Verification
REQ-036 LOAD_MOD ch1 with data[511:0]=0xA5..A5 -> ready high 1 cycle after LOAD; core_modulus[1023:512]=0xA5..A5; ch0 unchanged; done asserted.
REQ-037 EXP ch0, then MONT ch1 launched while ch0 runs; model cores return after 300 and 50 cycles -> both captured; STATUS reads running=00, res_valid=11.
REQ-038 READ_RESULT ch0 issued before its core_done -> FSM waits in WAIT_RES; on core_done with result 0x1234, fpga_to_arm_data[511:0]=0x1234 with valid high.
REQ-039 EXP ch0 while ch0 is running -> err=1, done asserted, ch0 start/resetn unaffected; a subsequent STATUS returns bit 8 = 1 and clears err.
REQ-040 Opcode 0, or channel 3 with NUM_CH=2 -> done, err=1, no core signal toggles.
REQ-041 resetn low for 1 cycle during active computation on both channels -> all core_resetn/core_start are 0 next cycle, STATUS reads 0, leds = IDLE.
